// File: rtl/mcu_bus_pkg.sv
// rtl/mcu_bus_pkg.sv - shared constants and types for the MCU bus slot scheduler
package mcu_bus_pkg;

    localparam int PHASES_DEFAULT = 8;
    localparam int PHASE_W        = 3;

    localparam logic SLOT_CPU = 1'b1;
    localparam logic SLOT_VID = 1'b0;

    typedef enum logic [1:0] {
        VG_IDLE,
        VG_VID,
        VG_SND,
        VG_REF
    } vid_grant_t;

endpackage

// File: rtl/mcu_busarb_if.sv
// rtl/mcu_busarb_if.sv - request inputs and mux select/ack outputs of the bus slot scheduler
interface mcu_busarb_if;
    import mcu_bus_pkg::*;

    logic               viden;
    logic               sndon;
    logic               sreq;
    logic               dma_req;
    logic               as_n;
    logic               addrsel;
    logic               ixdmab;
    logic               snden;
    logic               refb;
    logic               vid_ack;
    logic               snd_ack;
    logic               ref_ack;
    logic               dma_gnt;
    logic [PHASE_W-1:0] phase;
    logic               cpu_slot;

    modport slave (
        input  viden, sndon, sreq, dma_req, as_n,
        output addrsel, ixdmab, snden, refb, vid_ack, snd_ack, ref_ack,
               dma_gnt, phase, cpu_slot
    );

    modport master (
        output viden, sndon, sreq, dma_req, as_n,
        input  addrsel, ixdmab, snden, refb, vid_ack, snd_ack, ref_ack,
               dma_gnt, phase, cpu_slot
    );

endinterface

// File: rtl/mcu_slotgen.sv
// rtl/mcu_slotgen.sv - phase counter and CPU/video slot alternation
module mcu_slotgen
    import mcu_bus_pkg::*;
#(
    parameter int PHASES = PHASES_DEFAULT
) (
    input  logic               clk32,
    input  logic               res,
    output logic [PHASE_W-1:0] phase,
    output logic               cpu_slot,
    output logic               last_phase,
    output logic               slot_start
);

    localparam logic [PHASE_W-1:0] LAST = PHASE_W'(PHASES - 1);

    assign last_phase = (phase == LAST);
    assign slot_start = (phase == '0);

    // Count phases within a slot; flip slot side on every wrap, CPU slot first after reset
    always_ff @(posedge clk32) begin
        if (res) begin
            phase    <= '0;
            cpu_slot <= SLOT_CPU;
        end else if (last_phase) begin
            phase    <= '0;
            cpu_slot <= ~cpu_slot;
        end else begin
            phase    <= phase + 1'b1;
        end
    end

endmodule

// File: rtl/mcu_busarb.sv
// rtl/mcu_busarb.sv - DRAM slot arbiter between video/sound/refresh and CPU/disk DMA
module mcu_busarb
    import mcu_bus_pkg::*;
#(
    parameter int PHASES       = PHASES_DEFAULT,
    parameter int REF_INTERVAL = 64
) (
    input  logic          clk32,
    input  logic          res,
    mcu_busarb_if.slave   bus
);

    localparam int             RW       = $clog2(REF_INTERVAL);
    localparam logic [RW-1:0]  REF_LAST = RW'(REF_INTERVAL - 1);

    logic [PHASE_W-1:0] phase;
    logic               cpu_slot;
    logic               last_phase;
    logic               slot_start;

    vid_grant_t         grant_q,     grant_d;
    logic [RW-1:0]      ref_cnt_q,   ref_cnt_d;
    logic               ref_pend_q,  ref_pend_d;
    logic               sreq_pend_q, sreq_pend_d;
    logic               sreq_hist_q;
    logic               dma_gnt_q,   dma_gnt_d;
    logic               ixdmab_q,    ixdmab_d;
    logic               vid_ack_q,   vid_ack_d;
    logic               snd_ack_q,   snd_ack_d;
    logic               ref_ack_q,   ref_ack_d;
    logic               snd_taken;

    mcu_slotgen #(.PHASES(PHASES)) u_slotgen (
        .clk32      (clk32),
        .res        (res),
        .phase      (phase),
        .cpu_slot   (cpu_slot),
        .last_phase (last_phase),
        .slot_start (slot_start)
    );

    // Next slot decisions: taken on the last phase, so each slot sees stable selects
    always_comb begin
        grant_d    = grant_q;
        ref_cnt_d  = ref_cnt_q;
        ref_pend_d = ref_pend_q;
        dma_gnt_d  = dma_gnt_q;
        ixdmab_d   = ixdmab_q;
        vid_ack_d  = 1'b0;
        snd_ack_d  = 1'b0;
        ref_ack_d  = 1'b0;
        snd_taken  = 1'b0;

        if (last_phase) begin
            if (cpu_slot == SLOT_CPU) begin
                // Upcoming video slot: refresh beats sound beats video fetch
                if (ref_pend_q) begin
                    grant_d    = VG_REF;
                    ref_ack_d  = 1'b1;
                    ref_pend_d = 1'b0;
                end else if (sreq_pend_q && bus.sndon) begin
                    grant_d   = VG_SND;
                    snd_ack_d = 1'b1;
                    snd_taken = 1'b1;
                end else if (bus.viden) begin
                    grant_d   = VG_VID;
                    vid_ack_d = 1'b1;
                end else begin
                    grant_d = VG_IDLE;
                end
            end else begin
                // Upcoming CPU slot: DMA only takes over between CPU bus cycles
                grant_d = VG_IDLE;
                if (dma_gnt_q && !bus.dma_req) begin
                    dma_gnt_d = 1'b0;
                end else if (!dma_gnt_q && bus.dma_req && bus.as_n) begin
                    dma_gnt_d = 1'b1;
                end
                ixdmab_d = ~dma_gnt_d;
            end
        end

        // Every video slot ages the refresh interval by one
        if (slot_start && (cpu_slot == SLOT_VID)) begin
            if (ref_cnt_q == REF_LAST) begin
                ref_cnt_d  = '0;
                ref_pend_d = 1'b1;
            end else begin
                ref_cnt_d = ref_cnt_q + 1'b1;
            end
        end

        // A new sound request edge must not be lost to a grant in the same cycle
        if (bus.sreq && !sreq_hist_q) begin
            sreq_pend_d = 1'b1;
        end else if (snd_taken) begin
            sreq_pend_d = 1'b0;
        end else begin
            sreq_pend_d = sreq_pend_q;
        end
    end

    // Arbiter state registers
    always_ff @(posedge clk32) begin
        if (res) begin
            grant_q     <= VG_IDLE;
            ref_cnt_q   <= '0;
            ref_pend_q  <= 1'b0;
            sreq_pend_q <= 1'b0;
            sreq_hist_q <= 1'b0;
            dma_gnt_q   <= 1'b0;
            ixdmab_q    <= 1'b1;
            vid_ack_q   <= 1'b0;
            snd_ack_q   <= 1'b0;
            ref_ack_q   <= 1'b0;
        end else begin
            grant_q     <= grant_d;
            ref_cnt_q   <= ref_cnt_d;
            ref_pend_q  <= ref_pend_d;
            sreq_pend_q <= sreq_pend_d;
            sreq_hist_q <= bus.sreq;
            dma_gnt_q   <= dma_gnt_d;
            ixdmab_q    <= ixdmab_d;
            vid_ack_q   <= vid_ack_d;
            snd_ack_q   <= snd_ack_d;
            ref_ack_q   <= ref_ack_d;
        end
    end

    assign bus.phase    = phase;
    assign bus.cpu_slot = cpu_slot;
    assign bus.addrsel  = ~cpu_slot;
    assign bus.snden    = (grant_q == VG_SND);
    assign bus.refb     = (grant_q != VG_REF);
    assign bus.vid_ack  = vid_ack_q;
    assign bus.snd_ack  = snd_ack_q;
    assign bus.ref_ack  = ref_ack_q;
    assign bus.dma_gnt  = dma_gnt_q;
    assign bus.ixdmab   = ixdmab_q;

endmodule

// File: tb/tb_mcu_busarb.sv
// tb/tb_mcu_busarb.sv - self-checking bench for the bus slot scheduler
module tb_mcu_busarb;
    import mcu_bus_pkg::*;

    localparam int PH = 8;
    localparam int RI = 4;

    logic clk32;
    logic res;

    mcu_busarb_if bus();

    mcu_busarb #(.PHASES(PH), .REF_INTERVAL(RI)) dut (
        .clk32 (clk32),
        .res   (res),
        .bus   (bus.slave)
    );

    initial clk32 = 1'b0;
    always #5 clk32 = ~clk32;

    int checks   = 0;
    int failures = 0;

    // Reference state: slot position derived from cycles since reset
    int unsigned m_t;
    int unsigned m_nv;
    vid_grant_t  m_grant;
    bit          m_rp, m_sp, m_hist, m_gnt, m_ixd;
    int          ev[$];

    task automatic chk1(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_nv = 0; m_grant = VG_IDLE;
        m_rp = 0; m_sp = 0; m_hist = 0; m_gnt = 0; m_ixd = 1;
    endtask

    task automatic model_edge();
        int ph  = int'(m_t % PH);
        bit cpu = ((m_t / PH) % 2) == 0;
        bit clr = 0;
        if (ph == PH - 1 && cpu) begin
            if (m_rp) begin
                m_grant = VG_REF; m_rp = 0;
            end else if (m_sp && bus.sndon) begin
                m_grant = VG_SND; clr = 1;
            end else if (bus.viden) begin
                m_grant = VG_VID;
            end else begin
                m_grant = VG_IDLE;
            end
        end
        if (ph == PH - 1 && !cpu) begin
            if (m_gnt && !bus.dma_req) m_gnt = 0;
            else if (!m_gnt && bus.dma_req && bus.as_n) m_gnt = 1;
            m_ixd = !m_gnt;
        end
        if (ph == 0 && !cpu) begin
            m_nv++;
            if (m_nv % RI == 0) m_rp = 1;
        end
        if (bus.sreq && !m_hist) m_sp = 1;
        else if (clr) m_sp = 0;
        m_hist = bus.sreq;
        m_t++;
    endtask

    task automatic check_all();
        int ph  = int'(m_t % PH);
        bit cpu = ((m_t / PH) % 2) == 0;
        bit p0v = !cpu && ph == 0;
        chkn("phase",    int'(bus.phase), ph);
        chk1("cpu_slot", bus.cpu_slot, cpu);
        chk1("addrsel",  bus.addrsel, !cpu);
        chk1("refb",     bus.refb, !(!cpu && m_grant == VG_REF));
        chk1("snden",    bus.snden, !cpu && m_grant == VG_SND);
        chk1("vid_ack",  bus.vid_ack, p0v && m_grant == VG_VID);
        chk1("snd_ack",  bus.snd_ack, p0v && m_grant == VG_SND);
        chk1("ref_ack",  bus.ref_ack, p0v && m_grant == VG_REF);
        chk1("dma_gnt",  bus.dma_gnt, m_gnt);
        chk1("ixdmab",   bus.ixdmab, m_ixd);
    endtask

    task automatic tick();
        @(posedge clk32);
        if (res) model_reset();
        else model_edge();
        @(negedge clk32);
        check_all();
    endtask

    task automatic log_acks();
        if (bus.ref_ack) ev.push_back(1);
        if (bus.snd_ack) ev.push_back(2);
        if (bus.vid_ack) ev.push_back(3);
    endtask

    initial begin
        int n;
        int nvid;
        int nref;

        bus.viden = 0; bus.sndon = 0; bus.sreq = 0; bus.dma_req = 0; bus.as_n = 1;
        res = 1;
        model_reset();
        repeat (3) tick();
        chkn("rst_phase", int'(bus.phase), 0);
        chk1("rst_cpu_slot", bus.cpu_slot, 1'b1);
        chk1("rst_ixdmab", bus.ixdmab, 1'b1);
        chk1("rst_refb", bus.refb, 1'b1);
        res = 0;

        n = 0;
        while (bus.cpu_slot && n < 20) begin
            tick();
            n++;
        end
        chkn("first_fall", n, 8);

        bus.viden = 1;
        repeat (8) tick();
        nvid = 0; nref = 0;
        repeat (128) begin
            tick();
            nvid += int'(bus.vid_ack);
            nref += int'(bus.ref_ack);
        end
        chkn("vid_count", nvid, 6);
        chkn("ref_count", nref, 2);

        bus.sndon = 1;
        bus.sreq  = 1;
        tick();
        bus.sreq  = 0;
        ev.delete();
        n = 0;
        while (ev.size() < 2 && n < 48) begin
            tick();
            log_acks();
            n++;
        end
        chkn("snd_first", (ev.size() > 0) ? ev[0] : 0, 2);
        chkn("snd_then_vid", (ev.size() > 1) ? ev[1] : 0, 3);

        n = 0;
        while (!m_rp && n < 300) begin
            tick();
            n++;
        end
        bus.sreq = 1;
        tick();
        bus.sreq = 0;
        ev.delete();
        n = 0;
        while (ev.size() < 2 && n < 48) begin
            tick();
            log_acks();
            n++;
        end
        chkn("coinc_ref_first", (ev.size() > 0) ? ev[0] : 0, 1);
        chkn("coinc_snd_next", (ev.size() > 1) ? ev[1] : 0, 2);

        for (int i = 0; i < 1500; i++) begin
            if (m_t % PH == 0) bus.viden = ($urandom_range(0, 3) != 0);
            bus.sndon = ($urandom_range(0, 3) != 0);
            bus.sreq  = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 19) == 0) bus.dma_req = ~bus.dma_req;
            bus.as_n  = ($urandom_range(0, 2) != 0);
            res = (i >= 700 && i < 702);
            tick();
        end
        res = 0;

        bus.dma_req = 0; bus.as_n = 1; bus.sreq = 0;
        repeat (32) tick();
        bus.dma_req = 1; bus.as_n = 0;
        n = 0;
        repeat (40) begin
            tick();
            n += int'(bus.dma_gnt);
        end
        chkn("dma_held_off", n, 0);
        bus.as_n = 1;
        n = 0;
        while (!bus.dma_gnt && n < 2 * PH + 2) begin
            tick();
            n++;
        end
        chk1("dma_granted", bus.dma_gnt, 1'b1);
        n = 0;
        while (!(bus.cpu_slot && bus.phase == 0) && n < 2 * PH) begin
            tick();
            n++;
        end
        chk1("ixdmab_low", bus.ixdmab, 1'b0);

        bus.dma_req = 0;
        n = 0;
        while (!bus.ixdmab && n < 4 * PH) begin
            tick();
            n++;
        end
        chk1("ixdmab_back", bus.ixdmab, 1'b1);
        chk1("ixdmab_cpu_start", bus.cpu_slot && bus.phase == 0, 1'b1);

        bus.dma_req = 1;
        n = 0;
        while (!bus.dma_gnt && n < 4 * PH) begin
            tick();
            n++;
        end
        chk1("dma_regrant", bus.dma_gnt, 1'b1);
        repeat (3) tick();
        res = 1;
        tick();
        chk1("rst_dma_gnt", bus.dma_gnt, 1'b0);
        chk1("rst_cpu_slot2", bus.cpu_slot, 1'b1);
        res = 0;
        bus.dma_req = 0;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mcu_busarb.md
Name: mcu_busarb

Overview:
Bus slot scheduler for the MCU address-bus mux. It time-multiplexes DRAM between two sides:
- Video side: refresh, sound DMA or video fetch.
- CPU side: CPU or disk DMA.

It drives the mux selects addrsel, ixdmab, snden and refb, and issues the per-slot acknowledges that advance the video and sound counters. It replaces the constant tie-offs currently feeding the address mux.

Parameters:
- PHASES, 8: clk32 cycles per slot. One video slot plus one CPU slot makes a 500 ns memory cycle.
- REF_INTERVAL, 64: number of video slots between refresh requests; minimum 2.

Ports:
- clk32 in 1: system clock. All state changes on its rising edge.
- res in 1: reset, synchronous, active-high.
- viden in 1: video fetch window active.
- sndon in 1: sound DMA enabled.
- sreq in 1: sound FIFO request, level; rising edge captured.
- dma_req in 1: disk DMA wants the bus.
- as_n in 1: CPU address strobe, active low.
- addrsel out 1: 1 during a video-side slot.
- ixdmab out 1: 0 when DMA owns the CPU-side slot.
- snden out 1: sound address selected.
- refb out 1: 0 during a refresh slot.
- vid_ack out 1: one-cycle pulse when a video word is fetched.
- snd_ack out 1: one-cycle pulse when a sound word is fetched.
- ref_ack out 1: one-cycle pulse when a refresh is performed.
- dma_gnt out 1: DMA owns CPU-side slots.
- phase out 3: position within the current slot.
- cpu_slot out 1: 1 during a CPU-side slot.

Behaviour:
- Reset values: phase=0, cpu_slot=1, addrsel=0, ixdmab=1, snden=0, refb=1, all acks=0, dma_gnt=0, refresh counter=0, ref_pend=0, sreq_pend=0, sreq history=0.
- Reset mid-slot aborts the slot; nothing is carried over, and the first post-reset slot is a CPU slot.
- Phase counter: phase increments every clk32 and wraps PHASES-1 -> 0. At the wrap, cpu_slot toggles and addrsel = ~cpu_slot (new value).
- Decisions are registered at phase==PHASES-1 of the preceding slot and held constant for all PHASES cycles of the new slot. Requests are therefore sampled one cycle before the slot begins, giving 1..2*PHASES cycles of request-to-grant latency.
- Video-side decision, fixed priority, evaluated at the end of a CPU slot:
  1. ref_pend: refb=0, snden=0. ref_ack pulses at phase 0. ref_pend clears.
  2. else sreq_pend & sndon: snden=1, refb=1. snd_ack pulses at phase 0. sreq_pend clears.
  3. else viden: refb=1, snden=0. vid_ack pulses at phase 0.
  4. else idle: refb=1, snden=0, no ack. The mux shows the video address, but the counter does not advance.
- During CPU slots, snden=0 and refb=1.
- sreq capture: sreq_pend sets on a sreq 0->1 edge. If the set and the clear coincide, set wins. Additional edges while pending are absorbed, so there is at most one outstanding request. When sndon=0, sreq_pend is retained but never granted.
- Refresh: the counter increments at phase 0 of every video slot. When it reaches REF_INTERVAL-1 it wraps to 0 and sets ref_pend. Because refresh is highest priority, ref_pend is always serviced in the next video slot; it cannot overlap.
- CPU-side decision, evaluated at the end of a video slot:
  - If dma_gnt=1 and dma_req=0: release (dma_gnt=0).
  - If dma_gnt=0 and dma_req=1 and as_n=1: grant (dma_gnt=1). While as_n=0 the grant is deferred to the next decision point, so a CPU bus cycle is never cut.
  - Otherwise dma_gnt holds.
- ixdmab = ~dma_gnt, updated only at a CPU-slot start and held through the following video slot.
- Simultaneous sreq edge and refresh due: refresh goes first; sound follows in the next video slot.

Decomposition:
- Package mcu_bus_pkg holds:
  - slot side constants SLOT_CPU=1 and SLOT_VID=0;
  - video-side grant enum {VG_IDLE, VG_VID, VG_SND, VG_REF};
  - PHASES default.
- One sub-module, mcu_slotgen: phase counter plus cpu_slot toggle, exposing last_phase and slot_start strobes.
- The arbiter logic stays in the top-level mcu_busarb.

Test Plan:
- Reset held 3 cycles then released, all requests 0 -> all outputs at reset values; first cpu_slot falls after exactly 8 cycles; addrsel toggles every 8 cycles.
- viden=1 only, REF_INTERVAL=4 -> vid_ack once per 16 cycles; every 4th video slot has refb=0 with ref_ack instead of vid_ack.
- sndon=1, sreq pulse, viden=1 -> next video slot has snden=1 and snd_ack (no vid_ack); the following video slot returns to vid_ack.
- sreq edge in the same slot that refresh becomes due -> ref_ack in video slot N, snd_ack in slot N+1.
- dma_req=1 while as_n=0 for 40 cycles -> dma_gnt stays 0; once as_n=1 -> dma_gnt=1 and ixdmab=0 from the next CPU-slot start.
- Drop dma_req -> ixdmab returns to 1 at the following CPU slot; assert res mid-DMA -> dma_gnt=0 on the next edge.
